// File: rtl/branch_target_buffer_if.sv
// -----------------------------------------------------------------------------
// branch_target_buffer_if
// Signal bundle between the core pipeline and the branch target buffer.
//   master : pipeline side (drives lookup PC and resolved-branch updates,
//            receives the prediction and the performance counters)
//   slave  : branch target buffer side
// Signals:
//   lkup_pc          fetch PC to look up
//   pred_taken       predicted redirect for lkup_pc
//   pred_target      predicted next PC (target on predicted-taken, else PC+4)
//   upd_en           a resolved control-flow instruction is present
//   upd_pc           PC of the resolved instruction
//   upd_taken        actual direction outcome
//   upd_target       actual taken target
//   upd_jump         unconditional jump (always taken)
//   upd_mispredict   pipeline was flushed for this instruction
//   perf_branches    saturating count of resolved control-flow instructions
//   perf_mispredicts saturating count of mispredicted ones
// -----------------------------------------------------------------------------
interface branch_target_buffer_if;
   logic [31:0] lkup_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        upd_en;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        upd_jump;
   logic        upd_mispredict;
   logic [31:0] perf_branches;
   logic [31:0] perf_mispredicts;

   modport master (
      output lkup_pc, upd_en, upd_pc, upd_taken, upd_target, upd_jump, upd_mispredict,
      input  pred_taken, pred_target, perf_branches, perf_mispredicts
   );

   modport slave (
      input  lkup_pc, upd_en, upd_pc, upd_taken, upd_target, upd_jump, upd_mispredict,
      output pred_taken, pred_target, perf_branches, perf_mispredicts
   );
endinterface

// File: rtl/branch_target_buffer.sv
// -----------------------------------------------------------------------------
// branch_target_buffer
// Direct-mapped branch target buffer with per-entry saturating direction
// counters. The fetch stage looks up its PC combinationally and gets a
// predicted next PC in the same cycle; the execute/memory stage writes
// resolved outcomes back through the update signals, committed on the
// rising clock edge.
// Ports:
//   CLK   rising-edge clock
//   nRST  asynchronous active-low reset
//   bus   branch_target_buffer_if.slave (lookup, update, perf counters)
// Parameters:
//   ENTRIES  number of entries (power of two, >= 2)
//   CNT_BITS width of each direction counter (>= 1)
//   PERF_EN  1 instantiates the performance counters, 0 ties them to zero
// -----------------------------------------------------------------------------
module branch_target_buffer #(
   parameter int ENTRIES  = 16,
   parameter int CNT_BITS = 2,
   parameter bit PERF_EN  = 1'b1
) (
   input logic                   CLK,
   input logic                   nRST,
   branch_target_buffer_if.slave bus
);

   localparam int IDX   = $clog2(ENTRIES);
   localparam int TAG_W = 30 - IDX;

   localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);
   localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};
   localparam logic [CNT_BITS-1:0] CNT_WT  = CNT_ONE << (CNT_BITS - 1);
   localparam logic [CNT_BITS-1:0] CNT_WN  = CNT_WT - CNT_ONE;

   // Saturating counter helpers
   function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] c);
      return (c == CNT_MAX) ? CNT_MAX : c + CNT_ONE;
   endfunction

   function automatic logic [CNT_BITS-1:0] sat_dec(input logic [CNT_BITS-1:0] c);
      return (c == {CNT_BITS{1'b0}}) ? {CNT_BITS{1'b0}} : c - CNT_ONE;
   endfunction

   // Entry storage
   logic                valid_q  [ENTRIES];
   logic [TAG_W-1:0]    tag_q    [ENTRIES];
   logic [31:0]         target_q [ENTRIES];
   logic [CNT_BITS-1:0] cnt_q    [ENTRIES];

   // Lookup path
   logic [IDX-1:0]   lk_idx_s;
   logic [TAG_W-1:0] lk_tag_s;
   logic             lk_hit_s;
   logic             pred_taken_s;

   // Update path
   logic [IDX-1:0]      upd_idx_s;
   logic [TAG_W-1:0]    upd_tag_s;
   logic                upd_hit_s;
   logic                upd_t_s;
   logic                wr_en_s;
   logic [CNT_BITS-1:0] cnt_d;
   logic [31:0]         target_d;

   // PC byte-offset bits never take part in indexing or tagging
   logic unused_s;
   assign unused_s = ^{bus.lkup_pc[1:0], bus.upd_pc[1:0], bus.upd_mispredict};

   assign lk_idx_s  = bus.lkup_pc[IDX+1:2];
   assign lk_tag_s  = bus.lkup_pc[31:IDX+2];
   assign upd_idx_s = bus.upd_pc[IDX+1:2];
   assign upd_tag_s = bus.upd_pc[31:IDX+2];
   assign upd_t_s   = bus.upd_taken | bus.upd_jump;

   // Zero-latency lookup; always reads pre-update state (no write bypass)
   always_comb begin
      lk_hit_s        = valid_q[lk_idx_s] && (tag_q[lk_idx_s] == lk_tag_s);
      pred_taken_s    = lk_hit_s && cnt_q[lk_idx_s][CNT_BITS-1];
      bus.pred_taken  = pred_taken_s;
      if (pred_taken_s) begin
         bus.pred_target = target_q[lk_idx_s];
      end else begin
         bus.pred_target = bus.lkup_pc + 32'd4;
      end
   end

   // Next-state of the entry addressed by the update port
   always_comb begin
      upd_hit_s = valid_q[upd_idx_s] && (tag_q[upd_idx_s] == upd_tag_s);
      wr_en_s   = 1'b0;
      cnt_d     = cnt_q[upd_idx_s];
      target_d  = target_q[upd_idx_s];
      if (!bus.upd_en) begin
         wr_en_s = 1'b0;
      end else if (!upd_hit_s) begin
         // A taken miss allocates over whatever was there; a not-taken miss is dropped
         if (upd_t_s) begin
            wr_en_s  = 1'b1;
            cnt_d    = CNT_WT;
            target_d = bus.upd_target;
         end else begin
            wr_en_s = 1'b0;
         end
      end else if (bus.upd_jump) begin
         wr_en_s  = 1'b1;
         cnt_d    = CNT_MAX;
         target_d = bus.upd_target;
      end else if (upd_t_s) begin
         wr_en_s  = 1'b1;
         cnt_d    = sat_inc(cnt_q[upd_idx_s]);
         target_d = bus.upd_target;
      end else begin
         wr_en_s  = 1'b1;
         cnt_d    = sat_dec(cnt_q[upd_idx_s]);
      end
   end

   // Entry array state register
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= {TAG_W{1'b0}};
            target_q[i] <= 32'd0;
            cnt_q[i]    <= CNT_WN;
         end
      end else if (wr_en_s) begin
         valid_q[upd_idx_s]  <= 1'b1;
         tag_q[upd_idx_s]    <= upd_tag_s;
         target_q[upd_idx_s] <= target_d;
         cnt_q[upd_idx_s]    <= cnt_d;
      end
   end

   generate
      if (PERF_EN) begin : g_perf
         logic [31:0] branches_q;
         logic [31:0] mispredicts_q;
         logic [31:0] branches_d;
         logic [31:0] mispredicts_d;

         // Saturating performance counter next-state
         always_comb begin
            branches_d    = branches_q;
            mispredicts_d = mispredicts_q;
            if (bus.upd_en) begin
               if (branches_q != 32'hFFFF_FFFF) begin
                  branches_d = branches_q + 32'd1;
               end else begin
                  branches_d = branches_q;
               end
               if (bus.upd_mispredict && (mispredicts_q != 32'hFFFF_FFFF)) begin
                  mispredicts_d = mispredicts_q + 32'd1;
               end else begin
                  mispredicts_d = mispredicts_q;
               end
            end else begin
               branches_d    = branches_q;
               mispredicts_d = mispredicts_q;
            end
         end

         // Performance counter registers
         always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
               branches_q    <= 32'd0;
               mispredicts_q <= 32'd0;
            end else begin
               branches_q    <= branches_d;
               mispredicts_q <= mispredicts_d;
            end
         end

         assign bus.perf_branches    = branches_q;
         assign bus.perf_mispredicts = mispredicts_q;
      end else begin : g_no_perf
         assign bus.perf_branches    = 32'd0;
         assign bus.perf_mispredicts = 32'd0;
      end
   endgenerate

endmodule

// File: tb/tb_branch_target_buffer.sv
// -----------------------------------------------------------------------------
// tb_branch_target_buffer
// Scoreboard bench: each driven cycle pushes the expected prediction and perf
// counter values (from a behavioural model of the buffer) into a queue; a
// monitor pops and compares shortly after every falling edge.
// -----------------------------------------------------------------------------
module tb_branch_target_buffer;
   localparam int ENTRIES  = 16;
   localparam int CNT_BITS = 2;
   localparam int IDX      = 4;
   localparam int WT       = 1 << (CNT_BITS - 1);
   localparam int CMAX     = (1 << CNT_BITS) - 1;
   localparam int WN       = WT - 1;

   logic CLK  = 1'b0;
   logic nRST = 1'b0;

   always #5 CLK = ~CLK;

   branch_target_buffer_if bus ();

   branch_target_buffer #(
      .ENTRIES  (ENTRIES),
      .CNT_BITS (CNT_BITS),
      .PERF_EN  (1'b1)
   ) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   typedef struct {
      logic        tk;
      logic [31:0] tgt;
      logic [31:0] br;
      logic [31:0] mp;
      string       nm;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   // Behavioural model: one record per index, counter kept as a plain integer
   bit               m_v   [ENTRIES];
   longint unsigned  m_tag [ENTRIES];
   logic [31:0]      m_tgt [ENTRIES];
   int               m_cnt [ENTRIES];
   longint unsigned  m_br;
   longint unsigned  m_mp;

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc >> 2) % ENTRIES);
   endfunction

   function automatic longint unsigned tag_of(input logic [31:0] pc);
      return longint'(pc >> (IDX + 2));
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < ENTRIES; i++) begin
         m_v[i]   = 1'b0;
         m_tag[i] = 0;
         m_tgt[i] = 32'd0;
         m_cnt[i] = WN;
      end
      m_br = 0;
      m_mp = 0;
   endfunction

   function automatic exp_t model_predict(input logic [31:0] lk, input string nm);
      exp_t e;
      int   i;
      bit   hit;
      i    = idx_of(lk);
      hit  = m_v[i] && (m_tag[i] == tag_of(lk));
      e.tk  = hit && (m_cnt[i] >= WT);
      e.tgt = e.tk ? m_tgt[i] : lk + 32'd4;
      e.br  = m_br[31:0];
      e.mp  = m_mp[31:0];
      e.nm  = nm;
      return e;
   endfunction

   function automatic void model_update(input logic [31:0] upc, input logic tk,
                                        input logic [31:0] utg, input logic jmp,
                                        input logic misp);
      int i;
      bit hit;
      bit t;
      if (m_br < 64'hFFFF_FFFF) m_br++;
      if (misp && m_mp < 64'hFFFF_FFFF) m_mp++;
      t   = tk || jmp;
      i   = idx_of(upc);
      hit = m_v[i] && (m_tag[i] == tag_of(upc));
      if (!hit) begin
         if (t) begin
            m_v[i]   = 1'b1;
            m_tag[i] = tag_of(upc);
            m_tgt[i] = utg;
            m_cnt[i] = WT;
         end
      end else if (jmp) begin
         m_cnt[i] = CMAX;
         m_tgt[i] = utg;
      end else if (t) begin
         m_cnt[i] = (m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX;
         m_tgt[i] = utg;
      end else begin
         m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
      end
   endfunction

   // One clock of stimulus: drive at the falling edge, record the expectation,
   // then advance the model as the next rising edge will
   task automatic cycle(input logic [31:0] lk, input logic en, input logic [31:0] upc,
                        input logic tk, input logic [31:0] utg, input logic jmp,
                        input logic misp, input string nm);
      @(negedge CLK);
      bus.lkup_pc        = lk;
      bus.upd_en         = en;
      bus.upd_pc         = upc;
      bus.upd_taken      = tk;
      bus.upd_target     = utg;
      bus.upd_jump       = jmp;
      bus.upd_mispredict = misp;
      exp_q.push_back(model_predict(lk, nm));
      if (en) model_update(upc, tk, utg, jmp, misp);
   endtask

   // Assert reset between edges with an update pending; the effect must be
   // visible before the next rising edge and the update must be discarded
   task automatic rst_pulse(input logic [31:0] lk, input string nm);
      @(negedge CLK);
      nRST               = 1'b0;
      bus.lkup_pc        = lk;
      bus.upd_en         = 1'b1;
      bus.upd_pc         = lk;
      bus.upd_taken      = 1'b1;
      bus.upd_target     = 32'h0000_0AAC;
      bus.upd_jump       = 1'b0;
      bus.upd_mispredict = 1'b1;
      model_reset();
      exp_q.push_back(model_predict(lk, nm));
      @(posedge CLK);
      #1;
      nRST       = 1'b1;
      bus.upd_en = 1'b0;
   endtask

   function automatic logic [31:0] rand_pc();
      logic [31:0] pc;
      pc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
           | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) pc = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      return pc;
   endfunction

   // Scoreboard monitor: compare just after each falling edge, well clear of
   // the rising edge
   exp_t mon_e;
   always @(negedge CLK) begin
      #2;
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         checks++;
         if (bus.pred_taken !== mon_e.tk || bus.pred_target !== mon_e.tgt ||
             bus.perf_branches !== mon_e.br || bus.perf_mispredicts !== mon_e.mp) begin
            failures++;
            $display("FAIL %s: got taken=%0b target=%08h branches=%0d mispredicts=%0d, expected taken=%0b target=%08h branches=%0d mispredicts=%0d",
                     mon_e.nm, bus.pred_taken, bus.pred_target, bus.perf_branches,
                     bus.perf_mispredicts, mon_e.tk, mon_e.tgt, mon_e.br, mon_e.mp);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   localparam logic [31:0] A = 32'h0000_0040;
   localparam logic [31:0] T = 32'h0000_0100;

   initial begin
      bus.lkup_pc        = 32'd0;
      bus.upd_en         = 1'b0;
      bus.upd_pc         = 32'd0;
      bus.upd_taken      = 1'b0;
      bus.upd_target     = 32'd0;
      bus.upd_jump       = 1'b0;
      bus.upd_mispredict = 1'b0;
      model_reset();
      repeat (3) @(posedge CLK);
      #1;
      nRST = 1'b1;

      // Reset state and allocation
      cycle(A, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, "reset_lookup");
      cycle(A, 1'b1, A, 1'b1, T, 1'b0, 1'b0, "alloc_same_cycle_miss");
      cycle(A, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, "hit_after_alloc");
      cycle(32'h80, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, "alias_tag_miss");

      // Hysteresis
      cycle(A, 1'b1, A, 1'b0, 32'd0, 1'b0, 1'b1, "nt_update");
      cycle(A, 1'b1, A, 1'b1, T, 1'b0, 1'b0, "weak_nt_same_cycle");
      cycle(A, 1'b1, A, 1'b1, T, 1'b0, 1'b0, "taken_to_3");
      cycle(A, 1'b1, A, 1'b1, T, 1'b0, 1'b0, "taken_sat_3");
      cycle(A, 1'b1, A, 1'b0, 32'd0, 1'b0, 1'b1, "nt_from_3");
      cycle(A, 1'b1, A, 1'b0, 32'd0, 1'b0, 1'b0, "nt_from_2");
      cycle(A, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, "predict_nt_cnt1");
      cycle(A, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, "same_cycle_sees_old");
      cycle(A, 1'b1, A, 1'b1, 32'h0000_0104, 1'b0, 1'b0, "same_cycle_update");
      cycle(A, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, "next_cycle_new_target");

      // Jump allocation, jump saturation and alias eviction
      cycle(32'h200, 1'b1, 32'h200, 1'b0, 32'h300, 1'b1, 1'b1, "jump_alloc");
      cycle(32'h200, 1'b1, 32'h200, 1'b0, 32'h304, 1'b1, 1'b0, "jump_hit");
      cycle(32'h200, 1'b1, 32'h240, 1'b1, 32'h400, 1'b0, 1'b0, "evict_same_cycle");
      cycle(32'h200, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, "evicted_miss");
      cycle(32'h240, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, "evictor_hit");

      // Mispredict without enable is ignored; wrap of PC+4
      cycle(32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1, "misp_without_en");
      cycle(32'hFFFF_FFFC, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, "pc_wrap");
      cycle(32'hFFFF_FFFE, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, "pc_wrap_low_bits");
      rst_pulse(A, "async_reset_mid_run");
      cycle(A, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, "after_reset_miss");

      // Randomised traffic over a small PC pool so hits and aliases are frequent
      for (int n = 0; n < 1500; n++) begin
         logic [31:0] upc;
         upc = rand_pc();
         if ($urandom_range(0, 199) == 0) begin
            rst_pulse(rand_pc(), "rand_reset");
         end else begin
            cycle(($urandom_range(0, 3) == 0) ? upc : rand_pc(),
                  1'($urandom_range(0, 1)), upc, 1'($urandom_range(0, 1)),
                  $urandom & 32'hFFFF_FFFC, ($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 1)), "random");
         end
      end

      repeat (2) @(negedge CLK);
      #3;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- Parametrised, direct-mapped branch target buffer with per-entry saturating direction counters for the pipelined MIPS core.
- The fetch stage looks up the current PC combinationally and gets a predicted next PC. This replaces the fixed PC+4 fetch and the late branch redirect.
- The execute/memory stage writes resolved branch and jump outcomes back through the update port.
- Saturating performance counters track resolved branches and mispredictions.

Parameters:
ENTRIES, 16, number of BTB entries; power of two, at least 2; IDX = log2(ENTRIES)
CNT_BITS, 2, width of each direction counter; at least 1
PERF_EN, 1, 1 instantiates the performance counters; 0 ties perf outputs to 0

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
lkup_pc  in  32  fetch PC (word_t)
pred_taken  out  1  predict redirect this cycle
pred_target  out  32  predicted next PC
upd_en  in  1  resolved control-flow instruction present this cycle
upd_pc  in  32  PC of resolved instruction
upd_taken  in  1  actual outcome
upd_target  in  32  actual taken target
upd_jump  in  1  unconditional (J/JAL); treat as taken
upd_mispredict  in  1  pipeline flushed for this instruction; qualified by upd_en
perf_branches  out  32  count of upd_en cycles
perf_mispredicts  out  32  count of upd_en && upd_mispredict cycles

Behaviour:
- Address split:
  - index = pc[IDX+1:2]
  - tag = pc[31:IDX+2]
  - pc[1:0] ignored.
- Per-entry state: valid (1), tag (30-IDX), target (32), cnt (CNT_BITS).
- Lookup is purely combinational, zero latency.
  - hit = valid[i] && tag[i]==lkup_pc tag.
  - pred_taken = hit && cnt[i][CNT_BITS-1].
  - pred_target = pred_taken ? target[i] : lkup_pc+4. The add is 32-bit and wraps: 0xFFFFFFFC gives 0x00000000.
- Update is sequential, committed on the rising CLK with upd_en=1. Effective outcome t = upd_taken || upd_jump.
  - Miss and t=1: allocate. Set valid=1, tag=upd tag, target=upd_target, cnt=WT. Any previous occupant is overwritten.
  - Miss and t=0: no state change.
  - Hit and upd_jump=1: cnt=MAX, target=upd_target.
  - Hit, t=1, not jump: cnt saturating increment (holds at MAX), target=upd_target.
  - Hit and t=0: cnt saturating decrement (holds at 0). Target unchanged.
- Counter constants:
  - MAX = 2^CNT_BITS-1
  - WT (weakly taken) = 2^(CNT_BITS-1)
  - WN (weakly not taken) = WT-1
- Same-cycle lookup and update to the same index: lookup returns the pre-update state. There is no bypass; the new state is visible the next cycle.
- Reset (async, nRST=0):
  - all valid=0, cnt=WN, tag=0, target=0
  - perf counters = 0
  - pred_taken=0 and pred_target=lkup_pc+4, since no entry hits.
  - Reset asserted mid-operation discards any in-flight update that cycle.
- Perf counters (PERF_EN=1):
  - perf_branches +1 per upd_en cycle.
  - perf_mispredicts +1 per upd_en && upd_mispredict cycle.
  - Both saturate at 0xFFFFFFFF with no wrap.
  - upd_mispredict without upd_en is ignored.
- Unknown/X on lkup_pc must not corrupt state. The write path depends only on upd_* signals.
- CNT_BITS=1: WT=1, WN=0, MAX=1. The counter degenerates to a last-outcome bit.

Test Plan:
1. Reset, then lookup lkup_pc=0x00000040 -> pred_taken=0, pred_target=0x00000044; perf counters both 0.
2. Update upd_pc=0x40, upd_taken=1, upd_target=0x100 (miss, allocate). Next cycle lookup 0x40 -> pred_taken=1, pred_target=0x100. Lookup 0x80 (default config, same index 0, different tag) -> pred_taken=0, pred_target=0x84.
3. Hysteresis, CNT_BITS=2:
   - Allocate 0x40 taken (cnt=2).
   - One not-taken update -> cnt=1, pred_taken=0 on 0x40.
   - Two taken updates -> cnt=3.
   - Third taken update -> stays 3.
   - Two not-taken updates -> cnt=1, predicts not taken.
4. Same-cycle update and lookup to 0x40, after a not-taken update set cnt=1: upd_taken=1 and lookup 0x40 in the same cycle -> pred_taken=0 that cycle, 1 the next cycle.
5. Jump and alias eviction:
   - upd_jump=1 at 0x200 (ENTRIES=16) -> allocates with cnt=WT=2.
   - Second jump update -> cnt=3.
   - Taken update at 0x240 (same index 0, different tag) evicts it; 0x200 then misses.
6. Perf counters and wrap:
   - 5 upd_en cycles, 2 with upd_mispredict, plus one upd_mispredict cycle with upd_en=0 -> perf_branches=5, perf_mispredicts=2.
   - Lookup 0xFFFFFFFC on a miss -> pred_target=0x00000000.
   - nRST pulsed mid-sequence -> all counters 0 and all lookups miss immediately, without waiting for a clock edge.
